tron_reg_if_n: RTL and testbench

TRON_REG_IF_N -- requirements
Module: tron_reg_if_n

---
 rtl/tron_reg_if_n.sv | 131 +++++++++++++
 tb/tb_tron_reg_if_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tron_reg_if_n.sv
// tron_reg_if_n: per-player PicoBlaze register file with frame-tick commit, interrupt handshake and held-key keyboard state
module tron_reg_if_n #(
  parameter int NUM_PLAYERS = 2,
  parameter logic [16*NUM_PLAYERS-1:0] INIT_LOC = {8'h7D, 8'h7D, 8'h03, 8'h03},
  parameter logic [8*NUM_PLAYERS-1:0] INIT_ORIENT = {8'h03, 8'h01}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PLAYERS-1:0]     write_strobe,
  input  logic [NUM_PLAYERS-1:0]     read_strobe,
  input  logic [NUM_PLAYERS-1:0]     interrupt_ack,
  input  logic [8*NUM_PLAYERS-1:0]   port_id,
  input  logic [8*NUM_PLAYERS-1:0]   out_port,
  output logic [8*NUM_PLAYERS-1:0]   in_port,
  output logic [NUM_PLAYERS-1:0]     interrupt,
  input  logic                       sys_interrupt,
  input  logic [7:0]                 gameover,
  input  logic [15:0]                kb_code,
  input  logic                       kb_valid,
  output logic [8*NUM_PLAYERS-1:0]   loc_x,
  output logic [8*NUM_PLAYERS-1:0]   loc_y,
  output logic [8*NUM_PLAYERS-1:0]   orient,
  output logic [10*NUM_PLAYERS-1:0]  dig,
  output logic [8:0]                 kb_state
);
  typedef enum logic {IDLE, PEND} state_t;
  localparam logic [7:0] PMASK = 8'((16'd1 << (2 * NUM_PLAYERS)) - 16'd1);
  localparam logic [8:0] KMASK = {1'b1, PMASK};
  logic [8:0] kb_q, kb_d, kb_hit;
  logic [7:0] all_x [4];
  logic [7:0] all_y [4];
  logic [7:0] all_o [4];
  function automatic logic [8:0] key_bit(input logic [7:0] c);
    return c == 8'h29 ? 9'h100 :
           c == 8'h1C ? 9'h001 : c == 8'h1B ? 9'h002 :
           c == 8'h42 ? 9'h004 : c == 8'h4B ? 9'h008 :
           c == 8'h1A ? 9'h010 : c == 8'h22 ? 9'h020 :
           c == 8'h31 ? 9'h040 : c == 8'h3A ? 9'h080 : 9'h000;
  endfunction
  // Only 00xx make and F0xx break codes touch the held-key vector
  assign kb_hit = key_bit(kb_code[7:0]) & KMASK;
  assign kb_d = !kb_valid ? kb_q :
                kb_code[15:8] == 8'h00 ? (kb_q | kb_hit) :
                kb_code[15:8] == 8'hF0 ? (kb_q & ~kb_hit) : kb_q;
  always_ff @(posedge clk)
    kb_q <= reset ? 9'h000 : kb_d;
  assign kb_state = kb_q;
  for (genvar q = 0; q < 4; q++) begin : g_all
    if (q < NUM_PLAYERS) begin : g_on
      assign all_x[q] = loc_x[8*q +: 8];
      assign all_y[q] = loc_y[8*q +: 8];
      assign all_o[q] = orient[8*q +: 8];
    end else begin : g_off
      assign all_x[q] = 8'h00;
      assign all_y[q] = 8'h00;
      assign all_o[q] = 8'h00;
    end
  end
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_p
    state_t st_q, st_d;
    logic [7:0] sx_q, sy_q, so_q, cx_q, cy_q, co_q, ovr_q, rd_q, rd_d, wd;
    logic [4:0] d0_q, d1_q, a;
    logic int_q, we, ack, unused_p;
    assign a = port_id[8*p +: 5];
    assign wd = out_port[8*p +: 8];
    assign we = write_strobe[p];
    assign ack = interrupt_ack[p];
    assign unused_p = ^{read_strobe[p], port_id[8*p+5 +: 3]};
    always_comb begin
      rd_d = 8'h00;
      case (a)
        5'h00: rd_d = sx_q;
        5'h01: rd_d = sy_q;
        5'h02: rd_d = so_q;
        5'h04: rd_d = cx_q;
        5'h05: rd_d = cy_q;
        5'h06: rd_d = co_q;
        5'h08: rd_d = {kb_q[8], 5'b00000, kb_q[2*p+1], kb_q[2*p]};
        5'h09: rd_d = gameover;
        5'h0A: rd_d = ovr_q;
        5'h0B: rd_d = {3'b000, d0_q};
        5'h0C: rd_d = {3'b000, d1_q};
        default: rd_d = !a[4] ? 8'h00 :
                        a[3:2] == 2'b00 ? all_x[a[1:0]] :
                        a[3:2] == 2'b01 ? all_y[a[1:0]] :
                        a[3:2] == 2'b10 ? all_o[a[1:0]] : 8'h00;
      endcase
    end
    // A tick while still pending with an ack keeps the request up for the new frame
    assign st_d = st_q == IDLE ? (sys_interrupt ? PEND : IDLE) :
                  (ack && !sys_interrupt) ? IDLE : PEND;
    always_ff @(posedge clk) begin
      if (reset) begin
        sx_q  <= INIT_LOC[16*p +: 8];
        sy_q  <= INIT_LOC[16*p+8 +: 8];
        so_q  <= INIT_ORIENT[8*p +: 8];
        cx_q  <= INIT_LOC[16*p +: 8];
        cy_q  <= INIT_LOC[16*p+8 +: 8];
        co_q  <= INIT_ORIENT[8*p +: 8];
        d0_q  <= 5'd0;
        d1_q  <= 5'd0;
        ovr_q <= 8'h00;
        rd_q  <= 8'h00;
        st_q  <= IDLE;
        int_q <= 1'b0;
      end else begin
        rd_q <= rd_d;
        if (we && a == 5'h00) sx_q <= wd;
        if (we && a == 5'h01) sy_q <= wd;
        if (we && a == 5'h02) so_q <= wd;
        if (we && a == 5'h0B) d0_q <= wd[4:0];
        if (we && a == 5'h0C) d1_q <= wd[4:0];
        if (sys_interrupt) begin
          cx_q <= sx_q;
          cy_q <= sy_q;
          co_q <= so_q;
        end
        if (we && a == 5'h0A) ovr_q <= 8'h00;
        else if (st_q == PEND && sys_interrupt && !ack && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
        st_q  <= st_d;
        int_q <= st_d == PEND;
      end
    end
    assign in_port[8*p +: 8] = rd_q;
    assign loc_x[8*p +: 8] = cx_q;
    assign loc_y[8*p +: 8] = cy_q;
    assign orient[8*p +: 8] = co_q;
    assign dig[10*p +: 10] = {d1_q, d0_q};
    assign interrupt[p] = int_q;
  end
endmodule

// File: tb/tb_tron_reg_if_n.sv
// tb_tron_reg_if_n: directed stimulus with a read scoreboard for tron_reg_if_n (2 players), plus 1- and 4-player instances
module tb_tron_reg_if_n;
  logic clk = 1'b0;
  logic reset, sys, kbv;
  logic [3:0] ws, rs, ack;
  logic [31:0] pid, outp;
  logic [15:0] kbc;
  logic [7:0] go;
  logic [15:0] in2, lx2, ly2, or2;
  logic [1:0] int2;
  logic [19:0] dig2;
  logic [8:0] kb2, kb4, kb1;
  logic [31:0] in4, lx4, ly4, or4;
  logic [3:0] int4;
  logic [39:0] dig4;
  logic [7:0] in1, lx1, ly1, or1;
  logic int1;
  logic [9:0] dig1;
  int nchk = 0, nfail = 0;
  typedef struct {int p; logic [7:0] e; string n;} exp_t;
  exp_t sb[$];
  exp_t ex;
  logic [1:0] rs_q = 2'b00;

  always #5 clk = ~clk;

  tron_reg_if_n #(.NUM_PLAYERS(2)) u2 (
    .clk(clk), .reset(reset), .write_strobe(ws[1:0]), .read_strobe(rs[1:0]),
    .interrupt_ack(ack[1:0]), .port_id(pid[15:0]), .out_port(outp[15:0]), .in_port(in2),
    .interrupt(int2), .sys_interrupt(sys), .gameover(go), .kb_code(kbc), .kb_valid(kbv),
    .loc_x(lx2), .loc_y(ly2), .orient(or2), .dig(dig2), .kb_state(kb2));

  tron_reg_if_n #(.NUM_PLAYERS(4), .INIT_LOC(64'h4440_3330_2220_1110), .INIT_ORIENT(32'h04030201)) u4 (
    .clk(clk), .reset(reset), .write_strobe(ws), .read_strobe(rs),
    .interrupt_ack(ack), .port_id(pid), .out_port(outp), .in_port(in4),
    .interrupt(int4), .sys_interrupt(sys), .gameover(go), .kb_code(kbc), .kb_valid(kbv),
    .loc_x(lx4), .loc_y(ly4), .orient(or4), .dig(dig4), .kb_state(kb4));

  tron_reg_if_n #(.NUM_PLAYERS(1), .INIT_LOC(16'h0303), .INIT_ORIENT(8'h01)) u1 (
    .clk(clk), .reset(reset), .write_strobe(ws[0]), .read_strobe(rs[0]),
    .interrupt_ack(ack[0]), .port_id(pid[7:0]), .out_port(outp[7:0]), .in_port(in1),
    .interrupt(int1), .sys_interrupt(sys), .gameover(go), .kb_code(kbc), .kb_valid(kbv),
    .loc_x(lx1), .loc_y(ly1), .orient(or1), .dig(dig1), .kb_state(kb1));

  // Read data is due the cycle after a strobed read; pop and compare then
  always @(posedge clk) rs_q <= rs[1:0];
  always @(negedge clk)
    if (rs_q != 2'b00) begin
      nchk++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_read: got %h required no read", in2);
      end else begin
        ex = sb.pop_front();
        if (in2[8*ex.p +: 8] !== ex.e) begin
          nfail++;
          $display("FAIL %s: got %h required %h", ex.n, in2[8*ex.p +: 8], ex.e);
        end
      end
    end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [39:0] act, input logic [39:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  task automatic wr(input int p, input logic [7:0] a, input logic [7:0] d);
    pid[8*p +: 8] = a;
    outp[8*p +: 8] = d;
    ws[p] = 1'b1;
    step();
    ws[p] = 1'b0;
  endtask

  task automatic rd(input int p, input logic [7:0] a, input logic [7:0] e, input string n);
    pid[8*p +: 8] = a;
    rs[p] = 1'b1;
    sb.push_back('{p, e, n});
    step();
    rs[p] = 1'b0;
  endtask

  task automatic tick();
    sys = 1'b1;
    step();
    sys = 1'b0;
  endtask

  task automatic kb(input logic [15:0] c, input logic v);
    kbc = c;
    kbv = v;
    step();
    kbv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sys = 1'b0; kbv = 1'b0; ws = '0; rs = '0; ack = '0;
    pid = '0; outp = '0; kbc = '0; go = 8'h00;
    step(); step();
    chk("rst_loc_x", lx2, 16'h7D03);
    chk("rst_loc_y", ly2, 16'h7D03);
    chk("rst_orient", or2, 16'h0301);
    chk("rst_int", int2, 2'b00);
    chk("rst_kb", kb2, 9'h000);
    chk("rst_dig", dig2, 20'h0);
    chk("rst_in_port", in2, 16'h0000);
    chk("rst4_loc_x", lx4, 32'h40302010);
    chk("rst4_orient", or4, 32'h04030201);
    chk("rst1_loc_x", lx1, 8'h03);
    reset = 1'b0;
    wr(0, 8'h00, 8'h20);
    step();
    chk("no_tick_hold", lx2[7:0], 8'h03);
    rd(0, 8'h00, 8'h20, "shadow_x0");
    tick();
    chk("commit_x0", lx2[7:0], 8'h20);
    chk("tick_int", int2, 2'b11);
    chk("tick_int1", int1, 1'b1);
    rd(1, 8'h10, 8'h20, "cross_x0");
    rd(0, 8'h04, 8'h20, "own_x0");
    sys = 1'b1;
    wr(1, 8'h01, 8'h40);
    sys = 1'b0;
    chk("collide_old", ly2[15:8], 8'h7D);
    tick();
    chk("collide_new", ly2[15:8], 8'h40);
    ack = 4'hF; step(); ack = 4'h0;
    chk("ack_idle", int2, 2'b00);
    wr(0, 8'h0A, 8'h00);
    rd(0, 8'h0A, 8'h00, "ovr_cleared");
    tick();
    chk("int_set", int2[0], 1'b1);
    tick();
    rd(0, 8'h0A, 8'h01, "ovr_one");
    ack = 4'hF; sys = 1'b1; step(); ack = 4'h0; sys = 1'b0;
    chk("ack_tick_stay", int2, 2'b11);
    rd(0, 8'h0A, 8'h01, "ovr_ack_tick");
    ack = 4'hF; step(); ack = 4'h0;
    chk("ack_alone", int2, 2'b00);
    repeat (300) tick();
    rd(0, 8'h0A, 8'hFF, "ovr_sat");
    wr(0, 8'h0A, 8'h77);
    rd(0, 8'h0A, 8'h00, "ovr_wr_clear");
    wr(0, 8'h0B, 8'hE7);
    wr(0, 8'h0C, 8'h1F);
    wr(1, 8'h0B, 8'h05);
    rd(0, 8'h0B, 8'h07, "dig0_lo");
    rd(0, 8'h0C, 8'h1F, "dig0_hi");
    chk("dig_p0", dig2[9:0], 10'h3E7);
    chk("dig_p1", dig2[19:10], 10'h005);
    wr(0, 8'h04, 8'h99);
    rd(0, 8'h04, 8'h20, "ro_ignored");
    wr(0, 8'hE0, 8'h55);
    rd(0, 8'h00, 8'h55, "upper_bits_ignored");
    kb(16'h001C, 1'b1);
    chk("kb_make", kb2, 9'h001);
    chk("kb1_make", kb1, 9'h001);
    repeat (100) step();
    chk("kb_hold", kb2, 9'h001);
    kb(16'hF01C, 1'b1);
    chk("kb_break", kb2, 9'h000);
    kb(16'h0029, 1'b0);
    chk("kb_novalid", kb2, 9'h000);
    kb(16'h0029, 1'b1);
    chk("kb_start", kb2, 9'h100);
    rd(0, 8'h08, 8'h80, "kb_reg_p0");
    kb(16'h001A, 1'b1);
    chk("kb_p2_masked", kb2[4], 1'b0);
    chk("kb4_p2", kb4[4], 1'b1);
    kb(16'h004B, 1'b1);
    chk("kb_p1_r", kb2, 9'h108);
    chk("kb1_masked", kb1, 9'h100);
    rd(1, 8'h08, 8'h82, "kb_reg_p1");
    kb(16'h0055, 1'b1);
    chk("kb_unlisted", kb2, 9'h108);
    kb(16'hF029, 1'b1);
    chk("kb_start_break", kb2, 9'h008);
    go = 8'hA5;
    rd(0, 8'h09, 8'hA5, "gameover");
    rd(0, 8'h1F, 8'h00, "unmapped_1f");
    rd(0, 8'h13, 8'h00, "absent_p3");
    chk("u4_p3_x", in4[7:0], 8'h40);
    rd(0, 8'h03, 8'h00, "unmapped_03");
    rd(1, 8'h14, 8'h03, "cross_y0");
    rd(1, 8'h19, 8'h03, "cross_o1");
    chk("pre_rst_int", int2, 2'b11);
    reset = 1'b1; sys = 1'b1; kbc = 16'h001C; kbv = 1'b1;
    pid[7:0] = 8'h0B; outp[7:0] = 8'h1F; ws[0] = 1'b1;
    step();
    reset = 1'b0; sys = 1'b0; kbv = 1'b0; ws = '0;
    chk("mid_rst_loc_x", lx2, 16'h7D03);
    chk("mid_rst_loc_y", ly2, 16'h7D03);
    chk("mid_rst_orient", or2, 16'h0301);
    chk("mid_rst_int", int2, 2'b00);
    chk("mid_rst_kb", kb2, 9'h000);
    chk("mid_rst_dig", dig2, 20'h0);
    chk("mid_rst_in_port", in2, 16'h0000);
    chk("mid_rst_int1", int1, 1'b0);
    rd(0, 8'h00, 8'h03, "rst_shadow_x0");
    rd(0, 8'h0A, 8'h00, "rst_ovr");
    for (int i = 0; i < 5 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      nchk++;
      nfail++;
      $display("FAIL drain: got %0d pending reads required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
